// File: rtl/vdp_sync_recovery.sv
// vdp_sync_recovery: rebuilds the H/V counters from active-low hsync_n/vsync_n.
// It measures line length and lines per field, decides 50/60 Hz, tracks
// odd/even field phase and interlace, and runs a line-length lock FSM.
module vdp_sync_recovery #(
  parameter int LOCK_LINES       = 4,   // matching lines needed to lock (1..15)
  parameter int V_50HZ_THRESHOLD = 288  // lines_per_field above this is 50 Hz
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic [10:0] line_length,
  output logic [9:0]  lines_per_field,
  output logic        locked,
  output logic        field_odd,
  output logic        is_50hz,
  output logic        is_interlace
);

  localparam logic [10:0] H_MAX  = 11'h7FF;
  localparam logic [9:0]  V_MAX  = 10'h3FF;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_LINES);
  localparam logic [9:0]  V50_T  = 10'(V_50HZ_THRESHOLD);

  typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} lock_state_t;

  lock_state_t state, state_next;
  logic [3:0]  match_cnt, match_next;
  logic        hsync_d, vsync_d;
  logic        hs_edge, vs_edge;
  logic [10:0] h_meas;    // length of the line that ends at this hsync edge
  logic [9:0]  v_meas;    // lines in the field that ends at this vsync edge
  logic [10:0] h_pos;     // horizontal position of a vsync edge
  logic        fo_next;

  // Edges come from the current sample against last cycle's sample.
  assign hs_edge = hsync_d & ~hsync_n;
  assign vs_edge = vsync_d & ~vsync_n;

  assign h_meas = (h_count == H_MAX) ? H_MAX : h_count + 11'd1;
  assign v_meas = (v_count == V_MAX) ? V_MAX : v_count + 10'd1;

  // A vsync landing on the hsync edge sits at position 0, i.e. even field.
  assign h_pos   = hs_edge ? 11'd0 : h_count;
  assign fo_next = (h_pos >= (line_length >> 1));

  // Previous-sample registers; reset high so leaving reset makes no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else begin
      hsync_d <= hsync_n;
      vsync_d <= vsync_n;
    end
  end

  // Horizontal counter and line-length measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count     <= '0;
      line_length <= '0;
    end else if (hs_edge) begin
      h_count     <= '0;
      line_length <= h_meas;
    end else if (h_count != H_MAX) begin
      h_count <= h_count + 11'd1;
    end
  end

  // Vertical counter, field measurement and field-type flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_count         <= '0;
      lines_per_field <= '0;
      field_odd       <= 1'b0;
      is_interlace    <= 1'b0;
      is_50hz         <= 1'b0;
    end else if (vs_edge) begin
      v_count         <= '0;
      lines_per_field <= v_meas;
      field_odd       <= fo_next;
      is_interlace    <= (fo_next != field_odd);
      is_50hz         <= (v_meas > V50_T);
    end else if (hs_edge && v_count != V_MAX) begin
      v_count <= v_count + 10'd1;
    end
  end

  // Lock FSM next state: judged at each hsync edge, dropped on hsync loss.
  always_comb begin
    state_next = state;
    match_next = match_cnt;
    if (hs_edge) begin
      case (state)
        UNLOCKED: begin
          state_next = TRACK;
          match_next = '0;
        end
        TRACK: begin
          if (h_meas == line_length) begin
            match_next = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) state_next = LOCKED;
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          if (h_meas != line_length) begin
            state_next = TRACK;
            match_next = '0;
          end
        end
        default: begin
          state_next = UNLOCKED;
          match_next = '0;
        end
      endcase
    end else if (h_count == H_MAX) begin
      state_next = UNLOCKED;
      match_next = '0;
    end
  end

  // Lock FSM state register; locked is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
      locked    <= (state_next == LOCKED);
    end
  end

endmodule

// File: tb/tb_vdp_sync_recovery.sv
// Bench for vdp_sync_recovery: directed sync patterns, a cycle-level
// reference model built from plain integer bookkeeping, and literal checks.
module tb_vdp_sync_recovery;

  localparam int LOCK_LINES = 4;
  localparam int V50        = 288;

  logic        clk = 1'b0;
  logic        reset, hsync_n, vsync_n;
  logic [10:0] h_count, line_length;
  logic [9:0]  v_count, lines_per_field;
  logic        locked, field_odd, is_50hz, is_interlace;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  vdp_sync_recovery #(.LOCK_LINES(LOCK_LINES), .V_50HZ_THRESHOLD(V50)) dut (
    .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .h_count(h_count), .v_count(v_count), .line_length(line_length),
    .lines_per_field(lines_per_field), .locked(locked), .field_odd(field_odd),
    .is_50hz(is_50hz), .is_interlace(is_interlace)
  );

  always #5 clk = ~clk;

  // Reference model: h = clocks since last hsync edge, v = hsync edges since
  // last vsync edge, run = consecutive equal line lengths while tracking.
  typedef struct {
    int h, v, ll, lpf, run;
    bit fo, il, f50, sess, hsp, vsp;
  } mstate_t;

  function automatic mstate_t m_init();
    mstate_t s;
    s.h = 0; s.v = 0; s.ll = 0; s.lpf = 0; s.run = 0;
    s.fo = 0; s.il = 0; s.f50 = 0; s.sess = 0; s.hsp = 1; s.vsp = 1;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, bit hs_n, bit vs_n);
    mstate_t n;
    bit hs_e, vs_e, fo;
    int meas, pos;
    n = s;
    hs_e = s.hsp && !hs_n;
    vs_e = s.vsp && !vs_n;
    meas = (s.h + 1 > 2047) ? 2047 : s.h + 1;
    if (hs_e) begin
      if (!s.sess) begin n.sess = 1; n.run = 0; end
      else if (meas == s.ll) n.run = s.run + 1;
      else n.run = 0;
      n.ll = meas;
      n.h  = 0;
    end else begin
      n.h = (s.h >= 2047) ? 2047 : s.h + 1;
      if (s.h >= 2047) begin n.sess = 0; n.run = 0; end
    end
    if (vs_e) begin
      pos   = hs_e ? 0 : s.h;
      fo    = (pos >= s.ll / 2);
      n.il  = (fo != s.fo);
      n.fo  = fo;
      n.lpf = (s.v + 1 > 1023) ? 1023 : s.v + 1;
      n.f50 = (n.lpf > V50);
      n.v   = 0;
    end else if (hs_e) begin
      n.v = (s.v + 1 > 1023) ? 1023 : s.v + 1;
    end
    n.hsp = hs_n;
    n.vsp = vs_n;
    return n;
  endfunction

  mstate_t m;
  always @(posedge clk or posedge reset) begin
    if (reset) m <= m_init();
    else       m <= m_step(m, hsync_n, vsync_n);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("counters", {h_count, v_count}, {11'(m.h), 10'(m.v)});
      check("measure", {line_length, lines_per_field, locked, field_odd, is_50hz, is_interlace},
            {11'(m.ll), 10'(m.lpf), (m.sess && m.run >= LOCK_LINES), m.fo, m.f50, m.il});
    end
  end

  task automatic idle(int n, bit hs, bit vs);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); hsync_n = hs; vsync_n = vs;
    end
  endtask

  // One line: hsync low for 'low' clocks, optional 3-clock vsync at vs_at.
  task automatic line(int len, int low, int vs_at);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hsync_n = (i < low) ? 1'b0 : 1'b1;
      vsync_n = (vs_at >= 0 && i >= vs_at && i < vs_at + 3) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic plain(int n);
    for (int k = 0; k < n; k++) line(12, 3, -1);
  endtask

  task automatic all_zero(string name);
    check(name, {h_count, v_count, line_length, lines_per_field,
                 locked, field_odd, is_50hz, is_interlace}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
    cmp_en = 1'b1;
    idle(3, 1, 1);
    all_zero("reset_state");
    reset = 1'b0;
    idle(50, 1, 1);

    // 60 Hz timing, 1368-clock lines: lock on the 6th hsync edge.
    for (int k = 1; k <= 7; k++) begin
      line(1368, 100, -1);
      check($sformatf("lock_edge%0d", k), locked, (k >= 6));
    end
    check("line_len_1368", line_length, 11'd1368);

    // One short line drops lock; restored lines relock; hsync loss unlocks.
    line(1367, 100, -1);
    line(1368, 100, -1);
    check("short_line_len", line_length, 11'd1367);
    check("short_unlock", locked, 1'b0);
    for (int k = 0; k < 4; k++) line(1368, 100, -1);
    check("relock_pending", locked, 1'b0);
    line(1368, 100, -1);
    check("relock", locked, 1'b1);
    idle(2100, 1, 1);
    check("no_hsync_sat", h_count, 11'd2047);
    check("no_hsync_unlock", locked, 1'b0);

    // hsync held low: single edge, then saturation.
    idle(2100, 0, 1);
    check("hs_low_sat", h_count, 11'd2047);
    idle(5, 1, 1);
    idle(1, 0, 0);
    idle(1, 0, 0);
    check("simul_edges", {h_count, v_count, field_odd}, 22'd0);
    idle(3, 0, 1);
    idle(5, 1, 1);
    for (int k = 0; k < 1100; k++) line(8, 2, -1);
    check("v_sat", v_count, 10'd1023);

    // 60 Hz non-interlace fields of 262 lines (12-clock lines keep it short).
    line(12, 3, 0); plain(261);
    line(12, 3, 0); plain(261);
    line(12, 3, 0);
    check("lpf_262", lines_per_field, 10'd262);
    check("ni_flags", {is_50hz, is_interlace, field_odd}, 3'b000);
    check("short_len", line_length, 11'd12);

    // Interlace: next vsync lands mid-line, then back at line start.
    plain(261);
    line(12, 3, 7);
    check("il_odd", {field_odd, is_interlace, lines_per_field}, {2'b11, 10'd263});
    plain(262);
    line(12, 3, 0);
    check("il_even", {field_odd, is_interlace, lines_per_field}, {2'b01, 10'd263});
    check("il_60hz", is_50hz, 1'b0);

    // 50 Hz fields, then back to 262-line fields.
    plain(312); line(12, 3, 0);
    plain(312); line(12, 3, 0);
    check("lpf_313", {lines_per_field, is_50hz}, {10'd313, 1'b1});
    plain(261); line(12, 3, 0);
    check("back_to_60", {lines_per_field, is_50hz}, {10'd262, 1'b0});

    // Reset mid-frame at v_count 100, then relock on the 6th edge.
    plain(100);
    check("v_100", v_count, 10'd100);
    idle(5, 1, 1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1, 1, 1);
      all_zero("mid_reset");
    end
    reset = 1'b0;
    idle(20, 1, 1);
    check("no_edge_on_release", {h_count, v_count, line_length}, {11'd20, 10'd0, 11'd0});
    for (int k = 1; k <= 7; k++) begin
      line(100, 10, -1);
      check($sformatf("relock_edge%0d", k), locked, (k >= 6));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
